// File: rtl/cam_pixel_capture_if.sv
// ============================================================================
// Module   : cam_pixel_capture_if
// Purpose  : OV7670 byte bus and pixel BRAM write port bundled for capture.
//            CAM_FRAME_STATS_EN adds the per-frame statistics outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cam_pixel_capture_if #(
    parameter int ADDR_W = 19
);
    logic              i_cfg_done;
    logic [7:0]        i_pix_byte;
    logic              i_vsync;
    logic              i_href;
    logic              o_pix_wr;
    logic [11:0]       o_pix_data;
    logic [ADDR_W-1:0] o_pix_addr;
    logic              o_frame_done;
    logic              o_overflow;
`ifdef CAM_FRAME_STATS_EN
    logic [9:0]        o_line_cnt;
    logic [ADDR_W-1:0] o_frame_pix;

    modport master (
        output i_cfg_done, i_pix_byte, i_vsync, i_href,
        input  o_pix_wr, o_pix_data, o_pix_addr, o_frame_done, o_overflow,
        input  o_line_cnt, o_frame_pix
    );
    modport slave (
        input  i_cfg_done, i_pix_byte, i_vsync, i_href,
        output o_pix_wr, o_pix_data, o_pix_addr, o_frame_done, o_overflow,
        output o_line_cnt, o_frame_pix
    );
`else
    modport master (
        output i_cfg_done, i_pix_byte, i_vsync, i_href,
        input  o_pix_wr, o_pix_data, o_pix_addr, o_frame_done, o_overflow
    );
    modport slave (
        input  i_cfg_done, i_pix_byte, i_vsync, i_href,
        output o_pix_wr, o_pix_data, o_pix_addr, o_frame_done, o_overflow
    );
`endif
endinterface

`default_nettype wire

// File: rtl/cam_pixel_capture.sv
// ============================================================================
// Module   : cam_pixel_capture
// Purpose  : Pairs OV7670 RGB444 bytes into 12-bit pixels with linear BRAM
//            addressing, framed on VSYNC/HREF. Option: CAM_FRAME_STATS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cam_pixel_capture #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19
) (
    input  wire logic          i_pclk,
    input  wire logic          i_rstn_pclk,
    cam_pixel_capture_if.slave cam
);
    localparam logic [ADDR_W:0] PIX_TOTAL = (ADDR_W+1)'(IMG_W * IMG_H);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_CAPTURE    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              vsync_d;
    logic              phase;
    logic [3:0]        red;
    // One bit wider than the port so a full BRAM never wraps back to zero
    logic [ADDR_W:0]   addr_cnt;
    logic              pix_wr;
    logic [11:0]       pix_data;
    logic [ADDR_W-1:0] pix_addr;
    logic              frame_done;
    logic              overflow;

    logic vs_rise;
    logic vs_fall;
    logic frame_start;
    logic latch_red;
    logic pix_done;
    logic frame_end;
    logic addr_ok;

    assign vs_rise = cam.i_vsync & ~vsync_d;
    assign vs_fall = ~cam.i_vsync & vsync_d;
    assign addr_ok = addr_cnt < PIX_TOTAL;

    always_ff @(posedge i_pclk) begin
        if (!i_rstn_pclk) state <= ST_IDLE;
        else              state <= state_next;
    end

    // VSYNC rising beats a simultaneous HREF byte, dropping any partial pixel
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        latch_red   = 1'b0;
        pix_done    = 1'b0;
        frame_end   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cam.i_cfg_done) state_next = ST_WAIT_FRAME;
            end
            ST_WAIT_FRAME: begin
                if (vs_fall) begin
                    state_next  = ST_CAPTURE;
                    frame_start = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (vs_rise) begin
                    state_next = ST_WAIT_FRAME;
                    frame_end  = 1'b1;
                end else if (cam.i_href) begin
                    latch_red = ~phase;
                    pix_done  = phase;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_pclk) begin
        if (!i_rstn_pclk) begin
            vsync_d    <= 1'b0;
            phase      <= 1'b0;
            red        <= 4'd0;
            addr_cnt   <= '0;
            pix_wr     <= 1'b0;
            pix_data   <= 12'd0;
            pix_addr   <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            vsync_d    <= cam.i_vsync;
            phase      <= latch_red;
            pix_wr     <= 1'b0;
            frame_done <= frame_end;
            if (latch_red) red <= cam.i_pix_byte[3:0];
            if (frame_start) begin
                addr_cnt <= '0;
            end else if (pix_done && addr_ok) begin
                pix_wr   <= 1'b1;
                pix_data <= {red, cam.i_pix_byte};
                pix_addr <= addr_cnt[ADDR_W-1:0];
                addr_cnt <= addr_cnt + 1'b1;
            end
            if (pix_done && !addr_ok) overflow <= 1'b1;
        end
    end

    assign cam.o_pix_wr     = pix_wr;
    assign cam.o_pix_data   = pix_data;
    assign cam.o_pix_addr   = pix_addr;
    assign cam.o_frame_done = frame_done;
    assign cam.o_overflow   = overflow;

`ifdef CAM_FRAME_STATS_EN
    logic              href_d;
    logic              line_fall;
    logic [9:0]        line_run;
    logic [9:0]        line_cnt;
    logic [ADDR_W-1:0] frame_pix;

    assign line_fall = (state == ST_CAPTURE) & href_d & ~cam.i_href;

    always_ff @(posedge i_pclk) begin
        if (!i_rstn_pclk) begin
            href_d    <= 1'b0;
            line_run  <= 10'd0;
            line_cnt  <= 10'd0;
            frame_pix <= '0;
        end else begin
            href_d <= cam.i_href;
            if (frame_start)    line_run <= 10'd0;
            else if (line_fall) line_run <= line_run + 10'd1;
            if (frame_end) begin
                line_cnt  <= line_run + 10'(line_fall);
                frame_pix <= addr_cnt[ADDR_W-1:0];
            end
        end
    end

    assign cam.o_line_cnt  = line_cnt;
    assign cam.o_frame_pix = frame_pix;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cam_pixel_capture.sv
// ============================================================================
// Module   : tb_cam_pixel_capture
// Purpose  : Self-checking bench for cam_pixel_capture (small 4x2 image).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cam_pixel_capture;
    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int ADDR_W = 4;
    localparam int TOTAL  = IMG_W * IMG_H;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    cam_pixel_capture_if #(.ADDR_W(ADDR_W)) bus ();

    cam_pixel_capture #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
        .i_pclk      (clk),
        .i_rstn_pclk (rstn),
        .cam         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [11:0]       got_d[$];
    logic [ADDR_W-1:0] got_a[$];
    int                done_cnt = 0;
    logic [11:0]       exp_d[$];
    logic [ADDR_W-1:0] exp_a[$];
    int                m_addr;
    int                m_lines;
    bit                m_ovf;
    logic [7:0]        line_q[$];

    typedef struct {
        int nlines;
        int nbytes;
        int exp_wr;
        bit exp_ovf;
    } vec_t;
    vec_t tbl[6];

    always @(negedge clk) begin
        if (bus.o_pix_wr) begin
            got_d.push_back(bus.o_pix_data);
            got_a.push_back(bus.o_pix_addr);
        end
        if (bus.o_frame_done) done_cnt++;
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.i_href = 1'b0;
        repeat (n) tick();
    endtask

    task automatic clear_obs();
        got_d.delete(); got_a.delete();
        exp_d.delete(); exp_a.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset(input bit cfg);
        rstn = 1'b0;
        bus.i_cfg_done = cfg;
        bus.i_vsync    = 1'b0;
        bus.i_href     = 1'b0;
        bus.i_pix_byte = 8'h00;
        tick();
        tick();
        chk("rst_wr",   int'(bus.o_pix_wr),     0);
        chk("rst_data", int'(bus.o_pix_data),   0);
        chk("rst_addr", int'(bus.o_pix_addr),   0);
        chk("rst_done", int'(bus.o_frame_done), 0);
        chk("rst_ovf",  int'(bus.o_overflow),   0);
        rstn  = 1'b1;
        m_ovf = 1'b0;
        clear_obs();
    endtask

    // Reference: each line pairs its bytes; addresses run linearly per frame
    task automatic model_begin();
        m_addr  = 0;
        m_lines = 0;
    endtask

    task automatic model_line();
        if (line_q.size() > 0) m_lines++;
        for (int i = 0; i + 1 < line_q.size(); i += 2) begin
            if (m_addr < TOTAL) begin
                exp_d.push_back({line_q[i][3:0], line_q[i+1]});
                exp_a.push_back(ADDR_W'(m_addr));
                m_addr++;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic send_line();
        if (line_q.size() > 0) begin
            bus.i_href = 1'b1;
            foreach (line_q[i]) begin
                bus.i_pix_byte = line_q[i];
                tick();
            end
        end
        bus.i_href     = 1'b0;
        bus.i_pix_byte = 8'($urandom);
        idle(int'($urandom_range(1, 3)));
    endtask

    task automatic frame_open(input bit capture);
        bus.i_vsync = 1'b1;
        idle(3);
        bus.i_vsync = 1'b0;
        idle(2);
        if (capture) model_begin();
    endtask

    task automatic frame_close();
        bus.i_vsync = 1'b1;
        tick();
        idle(2);
    endtask

    task automatic run_frame(input int nlines, input int nbytes, input bit capture);
        frame_open(capture);
        for (int l = 0; l < nlines; l++) begin
            line_q.delete();
            for (int b = 0; b < nbytes; b++) line_q.push_back(8'($urandom));
            send_line();
            if (capture) model_line();
        end
        frame_close();
    endtask

    task automatic check_frame(input int exp_done);
        int n;
        chk("wr_count", got_d.size(), exp_d.size());
        n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            chk("pix_data", int'(got_d[i]), int'(exp_d[i]));
            chk("pix_addr", int'(got_a[i]), int'(exp_a[i]));
        end
        chk("frame_done_cnt", done_cnt, exp_done);
        chk("overflow", int'(bus.o_overflow), int'(m_ovf));
`ifdef CAM_FRAME_STATS_EN
        if (exp_done == 1) begin
            chk("line_cnt",  int'(bus.o_line_cnt),  m_lines);
            chk("frame_pix", int'(bus.o_frame_pix), exp_d.size());
        end
`endif
        clear_obs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0]  tp_bytes[4];
        logic [11:0] tp_pix[4];
        tp_bytes = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
        tp_pix   = '{12'h53C, 12'hFF0, 12'h53C, 12'hFF0};
        tbl[0] = '{2, 4, 4, 1'b0};
        tbl[1] = '{2, 3, 2, 1'b0};
        tbl[2] = '{3, 8, 8, 1'b1};
        tbl[3] = '{1, 1, 0, 1'b0};
        tbl[4] = '{3, 5, 6, 1'b0};
        tbl[5] = '{2, 8, 8, 1'b0};

        // Basic frame: 2 lines of A5 3C 0F F0, write exactly one cycle after byte 2
        do_reset(1'b1);
        frame_open(1'b1);
        for (int l = 0; l < 2; l++) begin
            line_q.delete();
            foreach (tp_bytes[i]) line_q.push_back(tp_bytes[i]);
            bus.i_href = 1'b1;
            for (int i = 0; i < 4; i++) begin
                bus.i_pix_byte = tp_bytes[i];
                tick();
                chk("latency_wr", int'(bus.o_pix_wr), i % 2);
            end
            model_line();
            idle(2);
        end
        bus.i_vsync = 1'b1;
        tick();
        chk("tp_frame_done", int'(bus.o_frame_done), 1);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            chk("tp_data", (i < got_d.size()) ? int'(got_d[i]) : -1, int'(tp_pix[i]));
            chk("tp_addr", (i < got_a.size()) ? int'(got_a[i]) : -1, i);
        end
        check_frame(1);

        // Unconfigured camera, then configuration arriving mid-frame
        do_reset(1'b0);
        run_frame(2, 4, 1'b0);
        check_frame(0);
        frame_open(1'b0);
        line_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_line();
        bus.i_cfg_done = 1'b1;
        send_line();
        frame_close();
        check_frame(0);
        run_frame(2, 4, 1'b1);
        check_frame(1);

        // Table of frame shapes, each from a fresh reset
        foreach (tbl[k]) begin
            do_reset(1'b1);
            run_frame(tbl[k].nlines, tbl[k].nbytes, 1'b1);
            chk("tbl_wr", got_d.size(), tbl[k].exp_wr);
            chk("tbl_ovf", int'(bus.o_overflow), int'(tbl[k].exp_ovf));
            chk("tbl_last_addr", int'(bus.o_pix_addr), (tbl[k].exp_wr > 0) ? tbl[k].exp_wr - 1 : 0);
            check_frame(1);
        end

        // VSYNC rising together with the second byte of a pixel
        do_reset(1'b1);
        frame_open(1'b1);
        bus.i_href     = 1'b1;
        bus.i_pix_byte = 8'h12;
        tick();
        bus.i_pix_byte = 8'h34;
        bus.i_vsync    = 1'b1;
        tick();
        chk("vs_win_wr",   int'(bus.o_pix_wr),     0);
        chk("vs_win_done", int'(bus.o_frame_done), 1);
        idle(2);
        check_frame(1);
        run_frame(1, 2, 1'b1);
        check_frame(1);

        // Reset in the middle of a line
        frame_open(1'b1);
        bus.i_href = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_pix_byte = 8'($urandom);
            tick();
        end
        rstn = 1'b0;
        tick();
        chk("midrst_wr",   int'(bus.o_pix_wr),     0);
        chk("midrst_data", int'(bus.o_pix_data),   0);
        chk("midrst_addr", int'(bus.o_pix_addr),   0);
        chk("midrst_done", int'(bus.o_frame_done), 0);
        rstn  = 1'b1;
        m_ovf = 1'b0;
        clear_obs();
        for (int i = 0; i < 6; i++) begin
            bus.i_pix_byte = 8'($urandom);
            tick();
        end
        idle(2);
        frame_close();
        check_frame(0);
        run_frame(2, 4, 1'b1);
        check_frame(1);

        // Randomised frames; overflow stays sticky across frames
        do_reset(1'b1);
        for (int f = 0; f < 25; f++) begin
            run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 9)), 1'b1);
            check_frame(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
- Pixel-domain capture stage between the OV7670 parallel bus and the dual-port pixel BRAM write port.
- Pairs RGB444 byte pairs into 12-bit pixels and generates a linear BRAM write address.
- Frames the write stream on VSYNC/HREF and flags frame completion and overflow.
- Runs entirely on PCLK.

Parameters:
IMG_W, 640, active pixels per line
IMG_H, 480, active lines per frame
ADDR_W, 19, BRAM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H

Ports:
i_pclk  in  1  camera pixel clock; sole clock
i_rstn_pclk  in  1  synchronous active-low reset, sampled on rising i_pclk
i_cfg_done  in  1  camera SCCB config complete (already synchronised to i_pclk); level
i_pix_byte  in  8  camera data byte
i_vsync  in  1  camera VSYNC, high = vertical blank
i_href  in  1  camera HREF, high = valid byte on bus
o_pix_wr  out  1  BRAM write strobe, one cycle per pixel
o_pix_data  out  12  pixel {R[3:0],G[3:0],B[3:0]}
o_pix_addr  out  ADDR_W  BRAM write address, valid with o_pix_wr
o_frame_done  out  1  one-cycle pulse at end of each captured frame
o_overflow  out  1  sticky: write attempted at address >= IMG_W*IMG_H

Behaviour:
- Reset (i_rstn_pclk low at a rising edge): state=IDLE. All outputs 0, byte-phase 0, address 0. Internal vsync_d register 0.
- Reset mid-frame aborts capture immediately. No write is issued in the reset cycle. After release the block re-syncs via WAIT_FRAME.
- vsync_d registers i_vsync each cycle. vs_rise = i_vsync & ~vsync_d; vs_fall = ~i_vsync & vsync_d.
- FSM:
  - IDLE: stay until i_cfg_done=1, then go to WAIT_FRAME.
  - WAIT_FRAME: ignore all href/data. On vs_fall go to CAPTURE, clear address and byte-phase. Never starts mid-frame.
  - CAPTURE:
    - Each cycle with i_href=1, toggle byte-phase.
    - Phase 0: latch i_pix_byte[3:0] as R (upper nibble discarded).
    - Phase 1: form pixel {R, i_pix_byte}.
    - On vs_rise: pulse o_frame_done for 1 cycle, go to WAIT_FRAME.
- Write latency: byte 2 sampled at edge N drives o_pix_wr=1, o_pix_data and o_pix_addr on outputs after edge N (registered, one cycle). Address post-increments by 1 after each write.
- When i_href=0, byte-phase forced to 0. An odd trailing byte at line end is discarded with no write.
- Address bound: a write at address >= IMG_W*IMG_H is suppressed (o_pix_wr stays 0), o_overflow sets, address holds. o_overflow clears only on reset.
- Simultaneous vs_rise and href=1 in CAPTURE: vsync wins. Byte dropped, partial pixel discarded, no write, frame_done pulses.
- i_cfg_done deasserts: finish current state transitions normally. IDLE is re-entered only by reset.
- o_pix_data and o_pix_addr hold their last values when o_pix_wr=0.

Optional Feature:
- Macro CAM_FRAME_STATS_EN. When defined, adds two outputs:
  - o_line_cnt [9:0]: number of href high->low transitions in the last completed frame.
  - o_frame_pix [ADDR_W-1:0]: number of pixels written in the last completed frame.
- Both update in the same cycle o_frame_done pulses and reset to 0.
- Internal counters clear on vs_fall.
- When undefined: neither port nor counter exists; remaining behaviour is identical.

Test Plan:
- Reset then i_cfg_done=1, then vsync 1->0, then 2 lines of 4 bytes (0xA5,0x3C,0x0F,0xF0) each, then vsync rise -> writes: data 0x53C @addr0, 0xFF0 @1, 0x53C @2, 0xFF0 @3; o_frame_done one pulse; latency exactly 1 cycle after byte 2.
- i_cfg_done=0 while full frame driven -> no o_pix_wr, no frame_done. Then cfg_done=1 mid-frame (vsync low) -> no writes until next vsync fall.
- Line with 3 bytes (odd) -> one write; 3rd byte discarded; next line's first pixel pairs correctly at next address.
- IMG_W=4, IMG_H=2, frame of 3 lines x 8 bytes -> 8 writes (addr 0..7); o_overflow=1 from first suppressed write; addr holds 7.
- vsync rises in the same cycle as byte 2 with href=1 -> no write for that pixel; frame_done pulses; next frame restarts at addr 0.
- Reset asserted mid-line -> outputs 0 next edge. After release and cfg_done, capture resumes only after a new vsync fall. With CAM_FRAME_STATS_EN, the 2-line frame reports o_line_cnt=2, o_frame_pix=4.
